// File: rtl/sentry_uart_pkg.sv
// Shared UART definitions for the sentry TX and RX paths.
// The PARITY state is only reached when SENTRY_TX_PARITY_EN is defined.
package sentry_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sentry_tx_fifo.sv
// Synchronous circular FIFO. The pointers carry one extra wrap bit so that
// full and empty can be told apart without a separate counter.
module sentry_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop && !empty) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // NOTE: clocked state uses <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; pointer reset alone makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/sentry_uart_tx.sv
// UART 8N1 transmitter with input FIFO for sentry status bytes.
// Define SENTRY_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module sentry_uart_tx
    import sentry_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_TX,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;

    logic       fifo_full, fifo_empty, fifo_pop;
    logic [7:0] fifo_rdata;
    logic       bit_end;

    sentry_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (CLOCK_50),
        .reset (reset),
        .push  (tx_valid),
        .wdata (tx_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tx_ready = !fifo_full;
    assign uart_TX  = tx_q;
    assign tx_busy  = (state_q != IDLE);
    assign bit_end  = (baud_cnt_q == CNT_LAST);

    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        fifo_pop   = 1'b0;

        if (state_q != IDLE) baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_d    = fifo_rdata;
                    tx_d       = 1'b0;
                    baud_cnt_d = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef SENTRY_TX_PARITY_EN
                        tx_d    = ^shift_q;
                        state_d = PARITY;
`else
                        tx_d    = UART_IDLE_LEVEL;
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[bit_idx_q + 3'd1];
                    end
                end
            end
`ifdef SENTRY_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    tx_d    = UART_IDLE_LEVEL;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // Chain straight into the next start bit so queued frames leave no idle gap.
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        tx_d     = 1'b0;
                        state_d  = START;
                    end else begin
                        tx_d    = UART_IDLE_LEVEL;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                tx_d       = UART_IDLE_LEVEL;
                baud_cnt_d = '0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= UART_IDLE_LEVEL;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_sentry_uart_tx.sv
// Directed bench for sentry_uart_tx at 10 clocks per bit; honours SENTRY_TX_PARITY_EN.
module tb_sentry_uart_tx;

    localparam int CPB = 10;
`ifdef SENTRY_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       CLOCK_50;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       uart_TX;
    logic       tx_busy;
    logic [3:0] fifo_count;

    sentry_uart_tx #(
        .CLK_HZ     (50000000),
        .BAUD       (5000000),
        .FIFO_DEPTH (8)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .uart_TX    (uart_TX),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int n_vec = 0;
    int n_bad = 0;

    // line_bits: left-most bit is the first data bit on the wire.
    typedef struct {
        logic [7:0] data;
        logic [7:0] line_bits;
        logic       par;
    } vec_t;

    vec_t       vecs[8];
    logic [7:0] burst[16];
    int         burst_n;
    int         acc_edge[16];
    int         acc_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] line_order(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = d[i];
        return r;
    endfunction

    task automatic wait_start(input int budget, output int waited);
        waited = 0;
        while (uart_TX !== 1'b0 && waited < budget) begin
            @(negedge CLOCK_50);
            waited++;
        end
    endtask

    // Called on the negedge of the first start-bit cycle; returns on the last stop-bit cycle.
    task automatic check_frame(input string name, input logic [7:0] line_bits, input logic par);
        logic [10:0] exp;
        logic [10:0] obs;
        int          off;
        int          busy_cyc;
        exp = '0;
        obs = '0;
        off = 0;
        busy_cyc = 0;
        for (int k = 1; k <= 8; k++) exp[k] = line_bits[8-k];
`ifdef SENTRY_TX_PARITY_EN
        exp[9] = par;
`endif
        exp[NBITS-1] = 1'b1;
        for (int b = 0; b < NBITS; b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (b != 0 || c != 0) @(negedge CLOCK_50);
                if (c == CPB / 2) obs[b] = uart_TX;
                if (uart_TX !== exp[b]) off++;
                if (tx_busy === 1'b1) busy_cyc++;
            end
        end
        check({name, " line bits"}, 32'(obs), 32'(exp));
        check({name, " off-level cycles"}, off, 0);
        check({name, " busy cycles"}, busy_cyc, NBITS * CPB);
    endtask

    // Holds tx_valid with burst[0..burst_n-1]; acc_edge[i] is the edge index that accepted byte i.
    task automatic push_burst();
        int   edge_i;
        logic rdy;
        edge_i = 0;
        acc_n  = 0;
        @(posedge CLOCK_50);
        #1;
        tx_valid = 1'b1;
        tx_data  = burst[0];
        while (acc_n < burst_n && edge_i < 2000) begin
            @(negedge CLOCK_50);
            rdy = tx_ready;
            @(posedge CLOCK_50);
            if (rdy) begin
                acc_edge[acc_n] = edge_i;
                acc_n++;
            end
            edge_i++;
            #1;
            if (acc_n < burst_n) tx_data = burst[acc_n];
            else tx_valid = 1'b0;
        end
        tx_valid = 1'b0;
        check("burst bytes accepted", acc_n, burst_n);
    endtask

    task automatic monitor_frames(input string name, input int n);
        int waited;
        wait_start(400, waited);
        check({name, " start seen"}, 32'(uart_TX), 0);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge CLOCK_50);
            check_frame($sformatf("%s[%0d]", name, i), line_order(burst[i]), ^burst[i]);
        end
        @(negedge CLOCK_50);
        check({name, " idle line"}, 32'(uart_TX), 1);
        check({name, " idle busy"}, 32'(tx_busy), 0);
        check({name, " idle count"}, 32'(fifo_count), 0);
    endtask

    task automatic check_quiet(input string name, input int cycles);
        int lows;
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLOCK_50);
            if (uart_TX !== 1'b1) lows++;
        end
        check(name, lows, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;

        vecs[0] = '{8'hA5, 8'b1010_0101, 1'b0};
        vecs[1] = '{8'h07, 8'b1110_0000, 1'b1};
        vecs[2] = '{8'h00, 8'b0000_0000, 1'b0};
        vecs[3] = '{8'hFF, 8'b1111_1111, 1'b0};
        vecs[4] = '{8'h3C, 8'b0011_1100, 1'b0};
        vecs[5] = '{8'h01, 8'b1000_0000, 1'b1};
        vecs[6] = '{8'h80, 8'b0000_0001, 1'b1};
        vecs[7] = '{8'h5A, 8'b0101_1010, 1'b0};

        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        // Reset state and idle line
        repeat (3) @(posedge CLOCK_50);
        #1 reset = 1'b0;
        @(negedge CLOCK_50);
        check("reset uart_TX", 32'(uart_TX), 1);
        check("reset tx_busy", 32'(tx_busy), 0);
        check("reset fifo_count", 32'(fifo_count), 0);
        check("reset tx_ready", 32'(tx_ready), 1);
        check_quiet("idle line after reset", 200);

        // Single frames from the vector table
        for (int v = 0; v < 8; v++) begin
            burst[0] = vecs[v].data;
            burst_n  = 1;
            push_burst();
            wait_start(20, waited);
            check($sformatf("vec %0h start latency", vecs[v].data), waited, 2);
            check_frame($sformatf("vec %0h", vecs[v].data), vecs[v].line_bits, vecs[v].par);
            @(negedge CLOCK_50);
            check($sformatf("vec %0h busy after frame", vecs[v].data), 32'(tx_busy), 0);
            check($sformatf("vec %0h line after frame", vecs[v].data), 32'(uart_TX), 1);
        end

        // Back-to-back burst of ten bytes with back-pressure
        for (int i = 0; i < 10; i++) burst[i] = 8'(i);
        burst_n = 10;
        fork
            push_burst();
            monitor_frames("b2b", 10);
        join
        for (int i = 0; i < 9; i++) check($sformatf("b2b accept edge %0d", i), acc_edge[i], i);
        check("b2b accept edge 9", acc_edge[9], 2 + NBITS * CPB);

        // Stall while full: 0xFF must be ignored
        for (int i = 0; i < 9; i++) burst[i] = 8'h20 + 8'(i);
        burst_n = 9;
        fork
            begin
                push_burst();
                @(negedge CLOCK_50);
                check("stall count before", 32'(fifo_count), 8);
                tx_data  = 8'hFF;
                tx_valid = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    @(negedge CLOCK_50);
                    check($sformatf("stall tx_ready %0d", i), 32'(tx_ready), 0);
                end
                tx_valid = 1'b0;
                @(negedge CLOCK_50);
                check("stall count after", 32'(fifo_count), 8);
            end
            monitor_frames("stall", 9);
        join

        // Reset in data bit 3 with a second byte queued
        burst[0] = 8'h3C;
        burst[1] = 8'h5A;
        burst_n  = 2;
        push_burst();
        @(negedge CLOCK_50);
        wait_start(20, waited);
        check("abort start seen", 32'(uart_TX), 0);
        repeat (44) @(negedge CLOCK_50);
        check("abort mid data bit 3", 32'(uart_TX), 1);
        check("abort queued count", 32'(fifo_count), 1);
        reset = 1'b1;
        @(posedge CLOCK_50);
        #1 reset = 1'b0;
        @(negedge CLOCK_50);
        check("abort uart_TX", 32'(uart_TX), 1);
        check("abort tx_busy", 32'(tx_busy), 0);
        check("abort fifo_count", 32'(fifo_count), 0);
        check("abort tx_ready", 32'(tx_ready), 1);
        check_quiet("abort no resume", 200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sentry_uart_tx.md
Name: sentry_uart_tx

Overview:
- UART 8N1 transmitter that carries sentry status bytes (servo position echo, fire acknowledge, fault codes) back to the host PC.
- It is the TX counterpart of the existing RX path.
- Byte-wide valid/ready input from the sentry state machine, an internal FIFO, and a serializer driving the uart_TX pin.
- Lives in the Nerf_Sentry top, clocked from CLOCK_50.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- BAUD, 115200, line rate; CLKS_PER_BIT = CLK_HZ/BAUD, truncated (434 at defaults).
- FIFO_DEPTH, 8, byte entries; must be a power of two, ≥2.

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- tx_data  in  8  byte to send.
- tx_valid  in  1  tx_data is valid this cycle.
- tx_ready  out  1  = !fifo_full; a byte is written on an edge where tx_valid && tx_ready.
- uart_TX  out  1  serial line, registered, idles high.
- tx_busy  out  1  high while a frame is on the line (state != IDLE).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries queued, excluding the byte in the shift register.

Behaviour:
- Reset values: uart_TX=1, tx_busy=0, fifo_count=0, tx_ready=1 (the cycle after reset), state=IDLE, baud counter=0.
- A reset mid-frame aborts the frame. uart_TX is high after the reset edge, the FIFO is flushed, and nothing resumes.
- FSM states: IDLE, START, DATA, STOP (plus PARITY under the macro). Each non-IDLE state holds for exactly CLKS_PER_BIT cycles, counted by baud_cnt from 0 to CLKS_PER_BIT-1.
- IDLE:
  - If fifo_count != 0, pop the head into shift_reg, set uart_TX=0, go to START.
  - Latency: uart_TX falls on the edge after the accepting edge when the FIFO was empty and the FSM was IDLE.
- START: at end of bit, go to DATA with bit_idx=0 and drive shift_reg[0].
- DATA:
  - LSB first; bit_idx increments at each bit end.
  - After bit 7 ends, go to STOP (or PARITY) with uart_TX=1.
- STOP: at end of bit:
  - If the FIFO is non-empty, pop and go straight to START with uart_TX=0; there is no idle gap between frames.
  - Otherwise go to IDLE.
- Frame length: 10*CLKS_PER_BIT cycles (11 with parity).
- FIFO:
  - Circular, with read/write pointers one bit wider than the index; full = MSBs differ and the rest are equal.
  - Push and pop on the same edge leave fifo_count unchanged.
  - Push is blocked when full (tx_ready=0). tx_valid while tx_ready=0 is ignored and the data is not captured; the upstream block must hold it.
  - Pop only occurs on empty→START transitions from IDLE/STOP, so it never underflows.
- Throughput: FIFO_DEPTH+1 bytes can be in flight (FIFO plus shift register).

Optional Feature:
- Macro: SENTRY_TX_PARITY_EN.
- Defined: a PARITY state is inserted after DATA.
  - It drives even parity, i.e. XOR of the 8 data bits, for CLKS_PER_BIT cycles.
  - Frame = 11 bits.
- Undefined: no PARITY state, no parity logic; plain 8N1.

Decomposition:
- Package sentry_uart_pkg:
  - state enum tx_state_t {IDLE, START, DATA, PARITY, STOP}.
  - constant UART_IDLE_LEVEL=1'b1.
  - function clks_per_bit(clk_hz, baud).
  - The RX block reuses it.
- Sub-module: sentry_tx_fifo (parameterised sync FIFO: push/pop/full/empty/count).
- The serializer FSM stays in sentry_uart_tx.

Test Plan:
All tests run with CLK_HZ=50000000 and BAUD=5000000, giving 10 clocks/bit.
1. Assert reset for 3 cycles, then release. Expect uart_TX=1, tx_busy=0, fifo_count=0, tx_ready=1, and the line stays high for 200 idle cycles.
2. Push 0xA5 once.
   - uart_TX goes low 1 cycle after acceptance for 10 cycles.
   - Then it sends 1,0,1,0,0,1,0,1 at 10 cycles each, then the stop bit high.
   - tx_busy is 1 for exactly 100 cycles.
3. Hold tx_valid with bytes 0x00..0x09 from an empty FIFO.
   - The first 9 are accepted on consecutive edges; tx_ready then drops.
   - 0x09 is accepted the edge after 0x01 is popped (end of frame 1).
   - All 10 frames go out back-to-back in 1000 cycles with no gap.
4. Push 0x3C, then assert reset during data bit 3. Expect uart_TX=1 after the reset edge, fifo_count=0, and no further low bit until a new push.
5. With tx_ready=0 (FIFO full), drive tx_valid with 0xFF for 5 cycles. Expect 0xFF never appears on the line and fifo_count is unchanged by the stall.
6. With SENTRY_TX_PARITY_EN defined, push 0x07. Expect data bits 1,1,1,0,0,0,0,0, then parity bit 1, then stop, for a total frame of 110 cycles.
